// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver: reassembles LSB-first frames into WIDTH-bit words
// and hands them to a double-buffered valid/ready output with a sticky overrun flag.
module shift_receiver #(
  parameter int WIDTH    = 8,
  parameter int SIGN_EXT = 0,
  parameter int SHORT_OK = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           shift,
  input  logic                           serial_in,
  input  logic                           end_frame,
  input  logic                           out_ready,
  input  logic                           clr_ovr,
  output logic [WIDTH-1:0]               data_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
  output logic                           overrun
);

  // state | meaning
  // IDLE  | waiting for start; shift and end_frame ignored
  // RECV  | frame in progress, bit_cnt bits collected in shreg (MSB-aligned)

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   shreg, shreg_nx;
  logic [CW-1:0]      cnt_nx;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   src_eff;
  logic [CW-1:0]      k_eff;
  logic [CW-1:0]      shamt;
  logic [WIDTH-1:0]   short_word;
  logic [WIDTH-1:0]   word;
  logic               deliver;

  assign shifted = {serial_in, shreg[WIDTH-1:1]};

  // A same-cycle shift is folded in before end_frame decides the short word.
  assign src_eff = shift ? shifted : shreg;
  assign k_eff   = shift ? bit_cnt + CW'(1) : bit_cnt;
  assign shamt   = CW'(WIDTH) - k_eff;

  always_comb begin
    short_word = src_eff >> shamt;
    if (SIGN_EXT != 0) begin
      // The last received bit sits at the MSB, so an arithmetic shift replicates it.
      short_word = $unsigned($signed(src_eff) >>> shamt);
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    deliver  = 1'b0;
    word     = shreg;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RECV;
          shreg_nx = '0;
          cnt_nx   = '0;
        end
      end
      RECV: begin
        if (start) begin
          shreg_nx = '0;
          cnt_nx   = '0;
        end else begin
          if (shift) begin
            shreg_nx = shifted;
            cnt_nx   = bit_cnt + CW'(1);
          end
          if (shift && bit_cnt == LAST) begin
            deliver  = 1'b1;
            word     = shifted;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (end_frame) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            if (SHORT_OK != 0 && k_eff != '0) begin
              deliver = 1'b1;
              word    = short_word;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        shreg_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= cnt_nx;
    end
  end

  assign busy = (state == RECV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        if (!out_valid || out_ready) begin
          data_out  <= word;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Set beats clear when both happen in one cycle.
      if (deliver && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver: a frame table plus hand-written sequences
// for reset, restart, drain and short-frame behaviour across three parameter sets.
module tb_shift_receiver;

  logic clk = 1'b0;
  logic reset_n, start, shift, serial_in, end_frame, out_ready, clr_ovr;

  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, b0, b1, b2, o0, o1, o2;
  logic [3:0] c0, c1, c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_receiver #(.WIDTH(8), .SIGN_EXT(0), .SHORT_OK(0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .shift(shift), .serial_in(serial_in),
    .end_frame(end_frame), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .data_out(d0), .out_valid(v0), .busy(b0), .bit_cnt(c0), .overrun(o0));

  shift_receiver #(.WIDTH(8), .SIGN_EXT(1), .SHORT_OK(1)) u_se (
    .clk(clk), .reset_n(reset_n), .start(start), .shift(shift), .serial_in(serial_in),
    .end_frame(end_frame), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .data_out(d1), .out_valid(v1), .busy(b1), .bit_cnt(c1), .overrun(o1));

  shift_receiver #(.WIDTH(8), .SIGN_EXT(0), .SHORT_OK(1)) u_ze (
    .clk(clk), .reset_n(reset_n), .start(start), .shift(shift), .serial_in(serial_in),
    .end_frame(end_frame), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .data_out(d2), .out_valid(v2), .busy(b2), .bit_cnt(c2), .overrun(o2));

  typedef struct {
    logic [7:0] tx;
    logic       rdy;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input logic rdy, input logic clr);
    @(negedge clk);
    start = 1'b1; clr_ovr = clr;
    @(negedge clk);
    start = 1'b0; clr_ovr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shift = 1'b1; serial_in = w[i]; out_ready = (i == 7) ? rdy : 1'b0;
      @(negedge clk);
    end
    shift = 1'b0; out_ready = 1'b0; serial_in = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // bits 1,0,1 then end_frame, either in a separate cycle or with the third shift
  task automatic short_frame(input logic together);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    shift = 1'b1; serial_in = 1'b1;
    @(negedge clk);
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    if (together) begin
      end_frame = 1'b1;
    end else begin
      @(negedge clk);
      shift = 1'b0; serial_in = 1'b0; end_frame = 1'b1;
    end
    @(negedge clk);
    shift = 1'b0; serial_in = 1'b0; end_frame = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{tx: 8'h4D, rdy: 1'b0, clr: 1'b0, exp_data: 8'h4D, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[1] = '{tx: 8'hA5, rdy: 1'b1, clr: 1'b0, exp_data: 8'hA5, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[2] = '{tx: 8'h3C, rdy: 1'b1, clr: 1'b0, exp_data: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[3] = '{tx: 8'h22, rdy: 1'b0, clr: 1'b0, exp_data: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b1};
    vecs[4] = '{tx: 8'h11, rdy: 1'b1, clr: 1'b1, exp_data: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[5] = '{tx: 8'h22, rdy: 1'b0, clr: 1'b0, exp_data: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b1};

    reset_n = 1'b0; start = 1'b0; shift = 1'b0; serial_in = 1'b0;
    end_frame = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset data_out", 32'(d0), 32'h0);
    chk("reset out_valid", 32'(v0), 32'h0);
    chk("reset busy", 32'(b0), 32'h0);
    chk("reset bit_cnt", 32'(c0), 32'h0);
    chk("reset overrun", 32'(o0), 32'h0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].tx, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d data_out", i), 32'(d0), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d out_valid", i), 32'(v0), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d overrun", i), 32'(o0), 32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d busy", i), 32'(b0), 32'h0);
      chk($sformatf("vec%0d bit_cnt", i), 32'(c0), 32'h0);
    end

    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("clr_ovr overrun", 32'(o0), 32'h0);
    chk("clr_ovr data held", 32'(d0), 32'h11);

    drain();
    chk("drain out_valid", 32'(v0), 32'h0);

    // restart: 5 bits of ones, then start together with shift
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift = 1'b1; serial_in = 1'b1;
      @(negedge clk);
    end
    chk("pre-restart bit_cnt", 32'(c0), 32'h5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; shift = 1'b0;
    chk("restart bit_cnt", 32'(c0), 32'h0);
    chk("restart busy", 32'(b0), 32'h1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h81;
      shift = 1'b1; serial_in = w[i];
      @(negedge clk);
    end
    shift = 1'b0; serial_in = 1'b0;
    chk("restart data_out", 32'(d0), 32'h81);
    chk("restart out_valid", 32'(v0), 32'h1);

    drain();
    short_frame(1'b0);
    chk("short sext data_out", 32'(d1), 32'hFD);
    chk("short sext out_valid", 32'(v1), 32'h1);
    chk("short zext data_out", 32'(d2), 32'h05);
    chk("short zext out_valid", 32'(v2), 32'h1);
    chk("short discard out_valid", 32'(v0), 32'h0);
    chk("short busy", 32'(b1), 32'h0);

    drain();
    short_frame(1'b1);
    chk("short+shift sext data_out", 32'(d1), 32'hFD);
    chk("short+shift zext data_out", 32'(d2), 32'h05);
    chk("short+shift discard busy", 32'(b0), 32'h0);

    drain();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; end_frame = 1'b1;
    @(negedge clk);
    end_frame = 1'b0;
    chk("empty frame out_valid", 32'(v1), 32'h0);
    chk("empty frame busy", 32'(b1), 32'h0);

    // async reset mid-frame with a word pending
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("pre-reset data_out", 32'(d0), 32'hC3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift = 1'b1; serial_in = 1'b1;
      @(negedge clk);
    end
    shift = 1'b0; serial_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async reset data_out", 32'(d0), 32'h0);
    chk("async reset out_valid", 32'(v0), 32'h0);
    chk("async reset busy", 32'(b0), 32'h0);
    chk("async reset bit_cnt", 32'(c0), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("post-reset data_out", 32'(d0), 32'h5A);
    chk("post-reset out_valid", 32'(v0), 32'h1);
    chk("post-reset overrun", 32'(o0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
